// File: rtl/div_issue_ctrl.sv
// Issue/capture controller for the multicycle combinational array divider.
// It registers the operands and holds them on the divider for SETTLE_CYCLES
// clocks. It then captures {remainder, quotient} into hi/lo and pulses done.
// A zero divisor bypasses the divider and completes one clock after start.
module div_issue_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      clear,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     dividend,
    input  logic [DATA_WIDTH-1:0]     divisor,
    output logic [DATA_WIDTH-1:0]     div_dividend,
    output logic [DATA_WIDTH-1:0]     div_divisor,
    input  logic [2*DATA_WIDTH-1:0]   div_result,
    output logic [DATA_WIDTH-1:0]     hi,
    output logic [DATA_WIDTH-1:0]     lo,
    output logic                      busy,
    output logic                      done,
    output logic                      div_zero
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    localparam logic [7:0] COUNT_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t                  state, state_nx;
    logic [7:0]              count, count_nx;
    logic [DATA_WIDTH-1:0]   opa_nx, opb_nx, hi_nx, lo_nx;
    logic                    zero_nx;

    // Next-state and next-value logic; every register holds unless updated.
    always_comb begin
        state_nx = state;
        count_nx = count;
        opa_nx   = div_dividend;
        opb_nx   = div_divisor;
        hi_nx    = hi;
        lo_nx    = lo;
        zero_nx  = div_zero;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    opa_nx = dividend;
                    opb_nx = divisor;
                    if (divisor == '0) begin
                        hi_nx    = '1;
                        lo_nx    = '1;
                        zero_nx  = 1'b1;
                        state_nx = DONE;
                    end else begin
                        count_nx = COUNT_LOAD;
                        zero_nx  = 1'b0;
                        state_nx = SETTLE;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            SETTLE: begin
                if (count != 8'd0) begin
                    count_nx = count - 8'd1;
                end else begin
                    hi_nx    = div_result[2*DATA_WIDTH-1:DATA_WIDTH];
                    lo_nx    = div_result[DATA_WIDTH-1:0];
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers; busy/done are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (clear) begin
            state        <= IDLE;
            count        <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            hi           <= '0;
            lo           <= '0;
            div_zero     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nx;
            count        <= count_nx;
            div_dividend <= opa_nx;
            div_divisor  <= opb_nx;
            hi           <= hi_nx;
            lo           <= lo_nx;
            div_zero     <= zero_nx;
            busy         <= (state_nx == SETTLE);
            done         <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural stand-in for the divider.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        clear, start;
    logic [31:0] dividend, divisor;
    logic [31:0] div_dividend, div_divisor;
    logic [63:0] div_result;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    int checks   = 0;
    int failures = 0;

    logic signed [31:0] q_s, r_s;

    always #5 clk = ~clk;

    div_issue_ctrl #(.DATA_WIDTH(32), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .clear(clear), .start(start),
        .dividend(dividend), .divisor(divisor),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_result(div_result),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    // Divider stand-in: signed quotient, remainder magnitude.
    always_comb begin
        q_s = '0;
        r_s = '0;
        div_result = 64'h1234_5678_9ABC_DEF0;
        if (div_divisor != 32'd0) begin
            q_s = $signed(div_dividend) / $signed(div_divisor);
            r_s = $signed(div_dividend) % $signed(div_divisor);
            if (r_s < 0) r_s = -r_s;
            div_result = {r_s, q_s};
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ops"}, {div_dividend, div_divisor}, 64'd0);
        check({tag, "_hilo"}, {hi, lo}, 64'd0);
        check({tag, "_flags"}, {61'd0, busy, done, div_zero}, 64'd0);
    endtask

    // Issue one request and follow it to completion, checking cycle-exact timing.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic ez);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        if (b != 32'd0) begin
            for (int i = 0; i < 4; i++) begin
                check("busy", {63'd0, busy}, 64'd1);
                check("done_early", {63'd0, done}, 64'd0);
                check("op_hold", {div_dividend, div_divisor}, {a, b});
                @(negedge clk);
            end
        end else begin
            check("zero_ops", {div_dividend, div_divisor}, {a, b});
        end
        check("done", {63'd0, done}, 64'd1);
        check("busy_off", {63'd0, busy}, 64'd0);
        check("hi", {32'd0, hi}, {32'd0, eh});
        check("lo", {32'd0, lo}, {32'd0, el});
        check("div_zero", {63'd0, div_zero}, {63'd0, ez});
        @(negedge clk);
        check("done_pulse", {63'd0, done}, 64'd0);
        check("hold_hilo", {hi, lo}, {eh, el});
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        check_all_zero("reset");

        run_op(32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op(32'hFFFF_FF9C, 32'd7, 32'd2, 32'hFFFF_FFF2, 1'b0);
        run_op(32'd55, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op(32'd0, 32'd5, 32'd0, 32'd0, 1'b0);

        // start pulsed during SETTLE must be ignored
        @(negedge clk);
        start = 1'b1; dividend = 32'd10; divisor = 32'd3;
        @(negedge clk);
        dividend = 32'd99; divisor = 32'd9;
        @(negedge clk);
        start = 1'b0; dividend = 32'd77; divisor = 32'd0;
        check("ign_ops", {div_dividend, div_divisor}, {32'd10, 32'd3});
        check("ign_busy", {63'd0, busy}, 64'd1);
        repeat (3) @(negedge clk);
        check("ign_done", {63'd0, done}, 64'd1);
        check("ign_hilo", {hi, lo}, {32'd1, 32'd3});
        @(negedge clk);
        check("ign_after", {62'd0, busy, done}, 64'd0);
        check("ign_ops2", {div_dividend, div_divisor}, {32'd10, 32'd3});

        // clear in the middle of SETTLE aborts without a done pulse
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_all_zero("abort");
        for (int i = 0; i < 5; i++) begin
            check("abort_quiet", {62'd0, busy, done}, 64'd0);
            @(negedge clk);
        end

        // back-to-back issue from DONE
        start = 1'b1; dividend = 32'd20; divisor = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("b2b_done1", {63'd0, done}, 64'd1);
        check("b2b_hilo1", {hi, lo}, {32'd0, 32'd5});
        start = 1'b1; dividend = 32'd9; divisor = 32'd2;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {62'd0, busy, done}, 64'd2);
        check("b2b_hold", {hi, lo}, {32'd0, 32'd5});
        repeat (3) @(negedge clk);
        check("b2b_still", {62'd0, busy, done}, 64'd2);
        @(negedge clk);
        check("b2b_done2", {63'd0, done}, 64'd1);
        check("b2b_hilo2", {hi, lo}, {32'd1, 32'd4});
        @(negedge clk);
        check("b2b_end", {62'd0, busy, done}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
